switch_bounce_gen: RTL and testbench

- Synthesizable mechanical-switch emulator: the driving end of the switch-to-debouncer interface.
- Converts a clean requested level into a realistic bouncy `sw` waveform: LFSR-driven chatter for a fixed window, then settles to the new level.
- Can also inject isolated single glitches on request.
- Used on-board and in benches to exercise the debouncers against repeatable, seedable bounce.

---
 rtl/switch_bounce_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_switch_bounce_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
// -----------------------------------------------------------------------------
// switch_bounce_gen
//
// Mechanical-switch emulator: the driving end of a switch-to-debouncer link.
// A clean requested level on level_in is turned into a bouncy waveform on sw.
// The leading edge is guaranteed, then LFSR-driven chatter follows for a fixed
// window of BOUNCE_TICKS * TICK_DIV cycles, and finally sw settles to the new
// level. Isolated single glitches of GLITCH_CYCLES width can be injected on
// request while idle. The LFSR is seedable, so bounce patterns are repeatable.
//
// Parameters
//   TICK_DIV        clock cycles per bounce tick
//   BOUNCE_TICKS    bounce window length in ticks (1..15)
//   CHATTER_CYCLES  clock cycles between LFSR advances during bounce
//   GLITCH_CYCLES   width of an injected glitch in cycles (>= 1)
//   LFSR_SEED       LFSR reset value (0 is replaced by 16'h0001)
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   level_in      in   clean requested switch level
//   glitch_req    in   one-cycle pulse: inject one glitch while idle
//   sw            out  emulated bouncy switch output (registered)
//   stable_level  out  last settled level
//   busy          out  high while bouncing or glitching
//   done          out  one-cycle pulse when a bounce window completes
//   edge_cnt      out  [15:0] sw transitions since window start, saturating
//                      (present only with SWITCH_BOUNCE_GEN_EDGE_CNT_EN)
//
// Optional feature macro: SWITCH_BOUNCE_GEN_EDGE_CNT_EN
// -----------------------------------------------------------------------------
module switch_bounce_gen #(
    parameter int unsigned TICK_DIV       = 1000000,
    parameter int unsigned BOUNCE_TICKS   = 2,
    parameter int unsigned CHATTER_CYCLES = 5000,
    parameter int unsigned GLITCH_CYCLES  = 20000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        level_in,
    input  logic        glitch_req,
    output logic        sw,
    output logic        stable_level,
    output logic        busy,
    output logic        done
`ifdef SWITCH_BOUNCE_GEN_EDGE_CNT_EN
    ,
    output logic [15:0] edge_cnt
`endif
);

    localparam int unsigned CYC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CHAT_W = (CHATTER_CYCLES > 1) ? $clog2(CHATTER_CYCLES) : 1;
    localparam int unsigned GLT_W  = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam int unsigned TICK_W = 4;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_DIV - 1);
    localparam logic [CHAT_W-1:0] CHAT_LAST = CHAT_W'(CHATTER_CYCLES - 1);
    localparam logic [GLT_W-1:0]  GLT_LAST  = GLT_W'(GLITCH_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(BOUNCE_TICKS);

    // An all-zero Fibonacci LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_GLITCH = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    state_t              state_q, state_d;
    logic                lvl_s_q;
    logic                target_q, target_d;
    logic                stable_q, stable_d;
    logic                sw_q, sw_d;
    logic                done_q, done_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [CHAT_W-1:0]   chat_q, chat_d;
    logic [GLT_W-1:0]    glt_q, glt_d;
    logic                win_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lvl_s_q  <= 1'b0;
            target_q <= 1'b0;
            stable_q <= 1'b0;
            sw_q     <= 1'b0;
            done_q   <= 1'b0;
            lfsr_q   <= SEED_EFF;
            cyc_q    <= '0;
            tick_q   <= '0;
            chat_q   <= '0;
            glt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lvl_s_q  <= level_in;
            target_q <= target_d;
            stable_q <= stable_d;
            sw_q     <= sw_d;
            done_q   <= done_d;
            lfsr_q   <= lfsr_d;
            cyc_q    <= cyc_d;
            tick_q   <= tick_d;
            chat_q   <= chat_d;
            glt_q    <= glt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        stable_d  = stable_q;
        sw_d      = sw_q;
        done_d    = 1'b0;
        lfsr_d    = lfsr_q;
        cyc_d     = cyc_q;
        tick_d    = tick_q;
        chat_d    = chat_q;
        glt_d     = glt_q;
        win_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                sw_d = stable_q;
                // A level change wins over a simultaneous glitch request.
                if (lvl_s_q != stable_q) begin
                    state_d   = S_BOUNCE;
                    target_d  = lvl_s_q;
                    sw_d      = lvl_s_q;
                    cyc_d     = '0;
                    tick_d    = '0;
                    chat_d    = '0;
                    win_start = 1'b1;
                end else if (glitch_req) begin
                    state_d = S_GLITCH;
                    sw_d    = ~stable_q;
                    glt_d   = '0;
                end
            end

            S_BOUNCE: begin
                if (lvl_s_q != target_q) begin
                    // Reversal mid-window: the window starts over towards the
                    // new target with a fresh leading edge. The LFSR keeps its
                    // state so the chatter sequence continues where it was.
                    target_d  = lvl_s_q;
                    sw_d      = lvl_s_q;
                    cyc_d     = '0;
                    tick_d    = '0;
                    chat_d    = '0;
                    win_start = 1'b1;
                end else begin
                    if (chat_q == CHAT_LAST) begin
                        chat_d = '0;
                        lfsr_d = lfsr_step(lfsr_q);
                    end else begin
                        chat_d = chat_q + 1'b1;
                    end

                    if (cyc_q == CYC_LAST) begin
                        cyc_d  = '0;
                        tick_d = tick_q + 1'b1;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end

                    if (tick_d == TICK_END) begin
                        state_d  = S_IDLE;
                        stable_d = target_q;
                        sw_d     = target_q;
                        done_d   = 1'b1;
                    end else begin
                        sw_d = lfsr_q[0];
                    end
                end
            end

            S_GLITCH: begin
                // level_in and glitch_req are deliberately not looked at here;
                // a pending level change is picked up once back in IDLE.
                sw_d = ~stable_q;
                if (glt_q == GLT_LAST) begin
                    state_d = S_IDLE;
                    sw_d    = stable_q;
                end else begin
                    glt_d = glt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sw           = sw_q;
    assign stable_level = stable_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

`ifdef SWITCH_BOUNCE_GEN_EDGE_CNT_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    // Counted on the edge where sw changes, so the settling edge is already
    // included while done is high. The window's own leading edge survives the
    // clear on entry.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (win_start) begin
            edge_cnt_d = {15'd0, (sw_d != sw_q)};
        end else if ((sw_d != sw_q) && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt_q <= 16'd0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`else
    logic unused_win_start;
    assign unused_win_start = win_start;
`endif

endmodule

// File: tb/tb_switch_bounce_gen.sv
module tb_switch_bounce_gen;

    localparam int TICK_DIV       = 10;
    localparam int BOUNCE_TICKS   = 3;
    localparam int CHATTER_CYCLES = 2;
    localparam int GLITCH_CYCLES  = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int WIN            = TICK_DIV * BOUNCE_TICKS;

    logic clk        = 1'b0;
    logic reset      = 1'b0;
    logic level_in   = 1'b0;
    logic glitch_req = 1'b0;
    logic sw, stable_level, busy, done;
`ifdef SWITCH_BOUNCE_GEN_EDGE_CNT_EN
    logic [15:0] edge_cnt;
`endif

    switch_bounce_gen #(
        .TICK_DIV      (TICK_DIV),
        .BOUNCE_TICKS  (BOUNCE_TICKS),
        .CHATTER_CYCLES(CHATTER_CYCLES),
        .GLITCH_CYCLES (GLITCH_CYCLES),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level_in    (level_in),
        .glitch_req  (glitch_req),
        .sw          (sw),
        .stable_level(stable_level),
        .busy        (busy),
`ifdef SWITCH_BOUNCE_GEN_EDGE_CNT_EN
        .edge_cnt    (edge_cnt),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    // Cycle c is the interval following the c-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic sw;
        logic busy;
        logic done;
        logic stable;
        int   edges;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_exp = 0;
    logic stable_m = 1'b0;
    int   n_adv = 0;

    function automatic void check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Reference LFSR: state after n advances from the seed.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        int taps[4] = '{16, 14, 13, 11};
        logic fb;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            fb = 1'b0;
            foreach (taps[t]) fb ^= s[taps[t]-1];
            s = {s[14:0], fb};
        end
        return s;
    endfunction

    function automatic void push(input int c, input logic s, input logic b, input logic d,
                                 input logic st, input int e);
        exp_t it;
        it.c = c; it.sw = s; it.busy = b; it.done = d; it.stable = st; it.edges = e;
        q.push_back(it);
    endfunction

    function automatic void idle_to(input int c_end);
        for (int c = next_exp; c <= c_end; c++) push(c, stable_m, 1'b0, 1'b0, stable_m, -1);
        if (c_end + 1 > next_exp) next_exp = c_end + 1;
    endfunction

    // Expected sw across the first len cycles of a bounce window starting at
    // cycle e: the target first, then the chatter bit that was current one
    // cycle earlier (n0 = LFSR advances made before the window).
    function automatic void push_window(input int e, input logic tgt, input int len, input int n0,
                                        inout logic last, inout int edges);
        logic [15:0] st;
        logic s;
        for (int k = 0; k < len; k++) begin
            if (k == 0) s = tgt;
            else begin
                st = lfsr_at(n0 + (k - 1) / CHATTER_CYCLES);
                s  = st[0];
            end
            if (s != last) edges++;
            last = s;
            push(e + k, s, 1'b1, 1'b0, stable_m, -1);
        end
    endfunction

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        int c;
        c = cyc;
        idle_to(c + n - 1);
        goto(c + n);
    endtask

    // Toggle level_in; r > 0 reverts it r cycles later.
    task automatic press(input int r);
        int   c, e, edges;
        logic tgt, last;
        c        = cyc;
        tgt      = ~stable_m;
        level_in = tgt;
        idle_to(c + 1);
        e     = c + 2;
        last  = stable_m;
        edges = 0;
        if (r > 0) begin
            push_window(e, tgt, r, n_adv, last, edges);
            n_adv += (r - 1) / CHATTER_CYCLES;
            e     += r;
            tgt    = stable_m;
            edges  = 0;
        end
        push_window(e, tgt, WIN, n_adv, last, edges);
        n_adv += WIN / CHATTER_CYCLES;
        if (last != tgt) edges++;
        stable_m = tgt;
        push(e + WIN, tgt, 1'b0, 1'b1, tgt, edges);
        next_exp = e + WIN + 1;
        if (r > 0) begin
            goto(c + r);
            level_in = ~level_in;
        end
        goto(next_exp);
    endtask

    // Glitch pulse; j2 > 0 issues a second request j2 cycles into the glitch.
    task automatic glitch(input int j2);
        int c;
        c = cyc;
        idle_to(c);
        glitch_req = 1'b1;
        for (int k = 1; k <= GLITCH_CYCLES; k++) push(c + k, ~stable_m, 1'b1, 1'b0, stable_m, -1);
        next_exp = c + GLITCH_CYCLES + 1;
        goto(c + 1);
        glitch_req = 1'b0;
        if (j2 > 0) begin
            goto(c + j2);
            glitch_req = 1'b1;
            goto(c + j2 + 1);
            glitch_req = 1'b0;
        end
        goto(next_exp);
    endtask

    task automatic reset_mid();
        int   c, e, edges;
        logic tgt, last;
        c        = cyc;
        tgt      = ~stable_m;
        level_in = tgt;
        idle_to(c + 1);
        e     = c + 2;
        last  = stable_m;
        edges = 0;
        push_window(e, tgt, 15, n_adv, last, edges);
        next_exp = e + 15;
        goto(e + 15);
        #1;
        check_bit("rstmid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_bit("rstmid_sw", sw, 1'b0);
        check_bit("rstmid_busy", busy, 1'b0);
        check_bit("rstmid_stable", stable_level, 1'b0);
        check_bit("rstmid_done", done, 1'b0);
        level_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        stable_m = 1'b0;
        n_adv    = 0;
        next_exp = cyc;
    endtask

    // Scoreboard monitor: compares every cycle that has an expected entry.
    always @(negedge clk) begin
        exp_t it;
        while (q.size() > 0 && q[0].c < cyc) begin
            it = q.pop_front();
            check_int("sb_order", it.c, cyc);
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            it = q.pop_front();
            check_bit($sformatf("c%0d_sw", cyc), sw, it.sw);
            check_bit($sformatf("c%0d_busy", cyc), busy, it.busy);
            check_bit($sformatf("c%0d_done", cyc), done, it.done);
            check_bit($sformatf("c%0d_stable", cyc), stable_level, it.stable);
`ifdef SWITCH_BOUNCE_GEN_EDGE_CNT_EN
            if (it.edges >= 0) check_int($sformatf("c%0d_edge_cnt", cyc), int'(edge_cnt), it.edges);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_bit("reset_sw", sw, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_stable", stable_level, 1'b0);
        reset    = 1'b1;
        next_exp = cyc;

        idle(100);
        press(0);
        idle(5);
        glitch(2);
        glitch(GLITCH_CYCLES);
        press(0);
        press(12);
        idle(3);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       press(0);
                1:       press(int'($urandom_range(1, 28)));
                2:       glitch(int'($urandom_range(0, GLITCH_CYCLES)));
                default: idle(int'($urandom_range(1, 10)));
            endcase
        end

        if (!stable_m) press(0);
        reset_mid();
        idle(3);
        press(0);
        glitch(0);
        press(int'($urandom_range(1, 28)));
        idle(4);

        goto(next_exp + 2);
        check_int("sb_drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
